// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the SNN spike-count classifier.
package snn_pkg;

   localparam int unsigned DEF_NEURON_NB = 4;
   localparam int unsigned DEF_NUM_STEPS = 16;
   localparam int unsigned DEF_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef logic [DEF_CNT_WIDTH-1:0] spike_cnt_t;

   // Index width never drops below one bit, even for a single class.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Step counter must be able to represent NUM_STEPS itself.
   function automatic int unsigned step_w(input int unsigned s);
      return (s > 0) ? $clog2(s + 1) : 1;
   endfunction

endpackage

// File: rtl/snn_sat_counter.sv
// Per-neuron spike counter: synchronous clear, increment, saturates at all-ones.
module snn_sat_counter #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/snn_spike_count_classifier.sv
// Accumulates output-layer spikes over NUM_STEPS timesteps, then scans the
// counters one per cycle to report the lowest-index neuron with the most spikes.
module snn_spike_count_classifier
   import snn_pkg::*;
#(
   parameter int unsigned NEURON_NB = DEF_NEURON_NB,
   parameter int unsigned NUM_STEPS = DEF_NUM_STEPS,
   parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NEURON_NB-1:0]           spike_in,
   input  logic                           spike_valid,
   output logic                           busy,
   output logic [idx_w(NEURON_NB)-1:0]    class_out,
   output logic [CNT_WIDTH-1:0]           max_count,
   output logic                           class_valid
);

   localparam int unsigned IDX_W  = idx_w(NEURON_NB);
   localparam int unsigned STEP_W = step_w(NUM_STEPS);

   state_t                state_q, state_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [IDX_W-1:0]      scan_q, scan_d;
   logic [IDX_W-1:0]      best_idx_q, best_idx_d;
   logic [CNT_WIDTH-1:0]  best_cnt_q, best_cnt_d;
   logic                  cnt_clr;
   logic [NEURON_NB-1:0]  cnt_inc;
   logic [CNT_WIDTH-1:0]  cnt [NEURON_NB];
   logic [CNT_WIDTH-1:0]  scan_cnt;

   for (genvar i = 0; i < NEURON_NB; i++) begin : g_cnt
      snn_sat_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .reset (reset),
         .clr   (cnt_clr),
         .inc   (cnt_inc[i]),
         .cnt   (cnt[i])
      );
   end

   // Counter currently under the argmax scan.
   always_comb begin
      scan_cnt = '0;
      for (int i = 0; i < NEURON_NB; i++) begin
         if (scan_q == IDX_W'(i)) begin
            scan_cnt = cnt[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         scan_q     <= '0;
         best_idx_q <= '0;
         best_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         scan_q     <= scan_d;
         best_idx_q <= best_idx_d;
         best_cnt_q <= best_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      scan_d     = scan_q;
      best_idx_d = best_idx_q;
      best_cnt_d = best_cnt_q;
      cnt_clr    = 1'b0;
      cnt_inc    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_clr = 1'b1;
               step_d  = '0;
               state_d = ST_ACCUM;
            end
         end

         ST_ACCUM: begin
            if (start) begin
               cnt_clr = 1'b1;
               step_d  = '0;
            end else if (spike_valid) begin
               cnt_inc = spike_in;
               step_d  = step_q + STEP_W'(1);
               if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                  state_d    = ST_ARGMAX;
                  scan_d     = '0;
                  best_idx_d = '0;
                  best_cnt_d = '0;
               end
            end
         end

         ST_ARGMAX: begin
            if (start) begin
               cnt_clr = 1'b1;
               step_d  = '0;
               state_d = ST_ACCUM;
            end else begin
               // Strict compare keeps the lowest index on ties.
               if (scan_cnt > best_cnt_q) begin
                  best_idx_d = scan_q;
                  best_cnt_d = scan_cnt;
               end
               if (scan_q == IDX_W'(NEURON_NB - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  scan_d = scan_q + IDX_W'(1);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               cnt_clr = 1'b1;
               step_d  = '0;
               state_d = ST_ACCUM;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Result registers load from the DONE cycle and hold until the next result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy        <= 1'b0;
         class_valid <= 1'b0;
         class_out   <= '0;
         max_count   <= '0;
      end else begin
         busy        <= (state_d == ST_ACCUM) || (state_d == ST_ARGMAX);
         class_valid <= (state_q == ST_DONE);
         if (state_q == ST_DONE) begin
            class_out <= best_idx_q;
            max_count <= best_cnt_q;
         end
      end
   end

endmodule

// File: tb/tb_snn_spike_count_classifier.sv
// Bench: two classifier configurations share one stimulus stream and are
// compared every cycle against a transaction-level reference model.
module tb_snn_spike_count_classifier;

   localparam int NN = 4;

   logic       clk;
   logic       reset;
   logic       start;
   logic       spike_valid;
   logic [3:0] spike_in;

   logic       busy_a, cv_a;
   logic [1:0] cls_a;
   logic [7:0] max_a;
   logic       busy_b, cv_b;
   logic [1:0] cls_b;
   logic [1:0] max_b;

   int checks = 0;
   int errors = 0;
   int pulses_a = 0;
   int pulses_b = 0;

   snn_spike_count_classifier #(.NEURON_NB(4), .NUM_STEPS(4), .CNT_WIDTH(8)) dut_a (
      .clk(clk), .reset(reset), .start(start), .spike_in(spike_in),
      .spike_valid(spike_valid), .busy(busy_a), .class_out(cls_a),
      .max_count(max_a), .class_valid(cv_a));

   snn_spike_count_classifier #(.NEURON_NB(4), .NUM_STEPS(8), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .reset(reset), .start(start), .spike_in(spike_in),
      .spike_valid(spike_valid), .busy(busy_b), .class_out(cls_b),
      .max_count(max_b), .class_valid(cv_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: counts as plain integers; the winner is decided the moment the
   // last step lands and released NN+1 cycles later unless start aborts it.
   typedef struct packed {
      logic             accum;
      int               steps;
      int               pend;
      logic [3:0][31:0] cnt;
      int               p_idx;
      int               p_cnt;
      logic             valid;
      int               cls;
      int               mx;
      logic             busy;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mstep(input mdl_t m, input logic st, input logic sv,
                                  input logic [3:0] spk, input int ns, input int cmax);
      mdl_t r = m;
      logic begin_acc = 1'b0;
      int   best_c, best_i;
      r.valid = 1'b0;
      if (m.pend == 1) begin
         r.valid = 1'b1;
         r.cls   = m.p_idx;
         r.mx    = m.p_cnt;
         r.pend  = 0;
         begin_acc = st;
      end else if (m.pend > 1) begin
         if (st) begin
            r.pend = 0;
            begin_acc = 1'b1;
         end else begin
            r.pend = m.pend - 1;
         end
      end else if (m.accum) begin
         if (st) begin
            begin_acc = 1'b1;
         end else if (sv) begin
            for (int i = 0; i < NN; i++)
               if (spk[i] && int'(r.cnt[i]) < cmax) r.cnt[i] = r.cnt[i] + 32'd1;
            r.steps = r.steps + 1;
            if (r.steps == ns) begin
               best_c = 0;
               best_i = 0;
               for (int i = 0; i < NN; i++)
                  if (int'(r.cnt[i]) > best_c) begin
                     best_c = int'(r.cnt[i]);
                     best_i = i;
                  end
               r.accum = 1'b0;
               r.p_idx = best_i;
               r.p_cnt = best_c;
               r.pend  = NN + 1;
            end
         end
      end else if (st) begin
         begin_acc = 1'b1;
      end
      if (begin_acc) begin
         r.accum = 1'b1;
         r.steps = 0;
         r.cnt   = '0;
      end
      r.busy = r.accum || (r.pend >= 2);
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic st, input logic sv, input logic [3:0] spk);
      start       = st;
      spike_valid = sv;
      spike_in    = spk;
      @(posedge clk);
      ma = mstep(ma, st, sv, spk, 4, 255);
      mb = mstep(mb, st, sv, spk, 8, 3);
      #1;
      chk("a_busy", int'(busy_a), int'(ma.busy));
      chk("a_valid", int'(cv_a), int'(ma.valid));
      chk("a_class", int'(cls_a), ma.cls);
      chk("a_max", int'(max_a), ma.mx);
      chk("b_busy", int'(busy_b), int'(mb.busy));
      chk("b_valid", int'(cv_b), int'(mb.valid));
      chk("b_class", int'(cls_b), mb.cls);
      chk("b_max", int'(max_b), mb.mx);
      if (cv_a) pulses_a++;
      if (cv_b) pulses_b++;
   endtask

   // Idle-cycle until a pulse appears on the chosen DUT; -1 if the bound expires.
   task automatic wait_pulse(input logic on_b, output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b0, 1'b0, 4'h0);
         if ((on_b ? cv_b : cv_a) && lat < 0) begin
            lat = k;
            break;
         end
      end
   endtask

   typedef struct packed {
      logic [3:0][3:0] spk;
      int              gap;
      int              cls;
      int              mx;
   } vec_t;

   vec_t vecs [5];
   int   lat;
   int   p0;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{spk: {4'b0100, 4'b0100, 4'b0100, 4'b0100}, gap: 0, cls: 2, mx: 4};
      vecs[1] = '{spk: {4'b1011, 4'b1010, 4'b1010, 4'b0000}, gap: 0, cls: 1, mx: 3};
      vecs[2] = '{spk: {4'b0000, 4'b0000, 4'b0000, 4'b0000}, gap: 2, cls: 0, mx: 0};
      vecs[3] = '{spk: {4'b0001, 4'b0011, 4'b0111, 4'b1111}, gap: 1, cls: 0, mx: 4};
      vecs[4] = '{spk: {4'b1000, 4'b1100, 4'b1110, 4'b0110}, gap: 0, cls: 2, mx: 3};

      reset = 1'b0;
      start = 1'b0;
      spike_valid = 1'b0;
      spike_in = 4'h0;
      ma = '0;
      mb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_valid", int'(cv_a), 0);
      chk("rst_class", int'(cls_a), 0);
      chk("rst_max", int'(max_a), 0);
      reset = 1'b1;
      repeat (2) cycle(1'b0, 1'b1, 4'hF);

      // Directed table on the 4-step configuration.
      for (int v = 0; v < 5; v++) begin
         p0 = pulses_a;
         cycle(1'b1, 1'b0, 4'h0);
         for (int s = 0; s < 4; s++) begin
            cycle(1'b0, 1'b1, vecs[v].spk[s]);
            if (s < 3) repeat (vecs[v].gap) cycle(1'b0, 1'b0, 4'h0);
         end
         chk("vec_early_pulse", pulses_a - p0, 0);
         wait_pulse(1'b0, lat);
         chk("vec_latency", lat, NN + 1);
         chk("vec_class", int'(cls_a), vecs[v].cls);
         chk("vec_max", int'(max_a), vecs[v].mx);
         chk("vec_busy", int'(busy_a), 0);
         repeat (3) cycle(1'b0, 1'b0, 4'h0);
      end

      // Saturation on the 2-bit, 8-step configuration.
      cycle(1'b1, 1'b0, 4'h0);
      repeat (3) cycle(1'b0, 1'b1, 4'b0011);
      repeat (5) cycle(1'b0, 1'b1, 4'b0001);
      wait_pulse(1'b1, lat);
      chk("sat_latency", lat, NN + 1);
      chk("sat_class", int'(cls_b), 0);
      chk("sat_max", int'(max_b), 3);
      repeat (3) cycle(1'b0, 1'b0, 4'h0);

      // Start on the DONE cycle keeps the pulse and begins a new inference.
      cycle(1'b1, 1'b0, 4'h0);
      repeat (4) cycle(1'b0, 1'b1, 4'b0001);
      repeat (NN) cycle(1'b0, 1'b0, 4'h0);
      cycle(1'b1, 1'b0, 4'h0);
      chk("done_start_pulse", int'(cv_a), 1);
      chk("done_start_busy", int'(busy_a), 1);
      chk("done_start_class", int'(cls_a), 0);
      repeat (4) cycle(1'b0, 1'b1, 4'b0010);
      wait_pulse(1'b0, lat);
      chk("done_start_lat", lat, NN + 1);
      chk("done_start_max", int'(max_a), 4);
      repeat (3) cycle(1'b0, 1'b0, 4'h0);

      // Abort after two steps; the discarded spike rides along with the restart.
      p0 = pulses_a;
      cycle(1'b1, 1'b0, 4'h0);
      repeat (2) cycle(1'b0, 1'b1, 4'b1000);
      cycle(1'b1, 1'b1, 4'b1000);
      repeat (4) cycle(1'b0, 1'b1, 4'b0010);
      wait_pulse(1'b0, lat);
      repeat (4) cycle(1'b0, 1'b0, 4'h0);
      chk("abort_pulses", pulses_a - p0, 1);
      chk("abort_class", int'(cls_a), 1);
      chk("abort_max", int'(max_a), 4);

      // Asynchronous reset in the middle of the scan.
      cycle(1'b1, 1'b0, 4'h0);
      repeat (4) cycle(1'b0, 1'b1, 4'b0100);
      repeat (2) cycle(1'b0, 1'b0, 4'h0);
      chk("pre_rst_busy", int'(busy_a), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", int'(busy_a), 0);
      chk("arst_valid", int'(cv_a), 0);
      chk("arst_class", int'(cls_a), 0);
      chk("arst_max", int'(max_a), 0);
      ma = '0;
      mb = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      p0 = pulses_a;
      repeat (8) cycle(1'b0, 1'b0, 4'h0);
      chk("arst_no_pulse", pulses_a - p0, 0);
      cycle(1'b1, 1'b0, 4'h0);
      cycle(1'b0, 1'b1, 4'b1001);
      cycle(1'b0, 1'b1, 4'b1000);
      cycle(1'b0, 1'b1, 4'b0001);
      cycle(1'b0, 1'b1, 4'b1000);
      wait_pulse(1'b0, lat);
      chk("post_rst_lat", lat, NN + 1);
      chk("post_rst_class", int'(cls_a), 3);
      chk("post_rst_max", int'(max_a), 3);

      // Random traffic against the model on both configurations.
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snn_spike_count_classifier.md
Name: snn_spike_count_classifier

Overview:
- Downstream consumer of the SNN output dense layer.
- Accumulates per-neuron output spikes over a fixed number of timesteps, then runs a sequential argmax over the spike counts.
- Emits the winning class index with a one-cycle valid pulse.
- This is the final inference-result stage of the network.

Parameters:
NEURON_NB, 4, number of output neurons / classes
NUM_STEPS, 16, timesteps accumulated per inference
CNT_WIDTH, 8, width of each per-neuron spike counter (saturating)
(localparam IDX_W = max(1, $clog2(NEURON_NB)); STEP_W = $clog2(NUM_STEPS+1))

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  begin new inference; clears counters
spike_in  input  NEURON_NB  spike vector for one timestep; bit i = neuron i fired
spike_valid  input  1  spike_in holds one valid timestep this cycle
busy  output  1  high in ACCUM or ARGMAX
class_out  output  IDX_W  winning neuron index, held until next result
max_count  output  CNT_WIDTH  spike count of the winner, held with class_out
class_valid  output  1  one-cycle pulse when class_out/max_count update

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All counters, step counter and scan index are cleared.
  - class_out=0, max_count=0, class_valid=0, busy=0.
- FSM states: IDLE, ACCUM, ARGMAX, DONE.
- IDLE:
  - spike_valid is ignored.
  - start=1 clears all counters and the step counter, then moves to ACCUM.
- ACCUM, on each cycle with spike_valid=1:
  - counter[i] increments where spike_in[i]=1, saturating at 2^CNT_WIDTH-1.
  - The step counter increments.
  - When the accepted step is the NUM_STEPS-th, go to ARGMAX on that same edge, with scan index=0, best_idx=0, best_cnt=0.
  - spike_valid=0 cycles are idle gaps; nothing changes.
- ARGMAX:
  - One neuron is compared per cycle, idx 0..NEURON_NB-1.
  - best is replaced only if counter[idx] > best_cnt (strict), so ties resolve to the lowest index.
  - After idx=NEURON_NB-1 is evaluated, go to DONE.
- DONE (one cycle):
  - class_out=best_idx, max_count=best_cnt, class_valid=1.
  - Next state is IDLE.
  - class_out and max_count hold until the next DONE or reset.
- Latency:
  - class_valid rises exactly NEURON_NB+1 cycles after the edge that accepts the final timestep.
  - A full inference with no gaps takes 1 + NUM_STEPS + NEURON_NB + 1 cycles from the start edge.
- start in ACCUM or ARGMAX:
  - Aborts the current inference and restarts: counters cleared, state ACCUM, no class_valid.
  - A spike_valid in the same cycle is discarded.
- start in DONE: is honoured (goes to ACCUM after the class_valid pulse) and does not suppress the pulse.
- start and spike_valid together in IDLE: start wins; the spike is not counted.
- All-zero counts: result is class_out=0, max_count=0, with class_valid still pulsed.
- busy=1 exactly in ACCUM and ARGMAX; busy=0 in IDLE and DONE.
- Arithmetic: counters are unsigned; comparison is unsigned over CNT_WIDTH bits.
- Legal configurations: NEURON_NB>=2, NUM_STEPS>=1. CNT_WIDTH<STEP_W is legal, with saturation defining the result.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum (IDLE/ACCUM/ARGMAX/DONE);
  - the IDX_W/STEP_W clog2 helper functions;
  - the spike-count typedef, parameterised by CNT_WIDTH via localparam.
- One natural sub-module is snn_sat_counter (clear, inc, saturating, CNT_WIDTH wide), instantiated NEURON_NB times.
- FSM and argmax scan stay in the top module.

Test Plan:
1. NEURON_NB=4, NUM_STEPS=4; start, then 4 steps of spike_in=4'b0100 -> after the 4th step + 5 cycles: class_valid=1, class_out=2, max_count=4, busy=0.
2. Tie: neurons 1 and 3 each fire 3 of 4 steps, neuron 0 fires once -> class_out=1, max_count=3.
3. No spikes over 4 steps, with spike_valid gaps of 2 idle cycles between steps -> class_out=0, max_count=0; the pulse arrives after the 4th valid step, not before.
4. CNT_WIDTH=2, NUM_STEPS=8; neuron 0 fires all 8 steps, neuron 1 fires 3 steps -> both saturate at 3, class_out=0, max_count=3.
5. Abort: start asserted again after 2 steps of spike_in=4'b1000, then 4 steps of 4'b0010 -> a single class_valid with class_out=1, max_count=4.
6. Reset: reset=0 mid-ARGMAX -> busy, class_valid, class_out and max_count drop to 0 immediately (asynchronous) and no pulse follows; after release, a normal inference completes correctly.
